// File: rtl/sram_port_pkg.sv
// Shared defaults and the response record for the SRAM port master.
package sram_port_pkg;

  localparam int SRAM_ADDR_W = 25;
  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_MASK_W = SRAM_DATA_W / 8;
  localparam int SRAM_DEPTH  = 4;

  // One queued response: write ack (data forced to zero) or read data.
  typedef struct packed {
    logic                   write;
    logic [SRAM_DATA_W-1:0] data;
  } sram_resp_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Response queue: circular buffer with explicit occupancy count.
module sram_resp_fifo
  import sram_port_pkg::*;
#(
  parameter  int WIDTH = 1 + SRAM_DATA_W,
  parameter  int DEPTH = SRAM_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, not at the power of two above it.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A pop on an empty queue is ignored; a push on a full queue only lands if a pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_port_master.sv
// SRAM port master: accepts read/write requests, drives a 1R1W SRAM macro,
// and returns in-order responses through a credit-limited response queue.
module sram_port_master
  import sram_port_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int MASK_W = DATA_W / 8,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [MASK_W-1:0] req_mask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_data,
  output logic              W0_clk,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data,
  output logic [MASK_W-1:0] W0_mask,
  output logic              R0_clk,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int RESP_W = 1 + DATA_W;

  logic              ready_r;
  logic [CNT_W-1:0]  credits;
  logic [CNT_W-1:0]  credits_nxt;
  logic              req_fire;
  logic              resp_fire;

  logic              vld_p0;
  logic              wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic [MASK_W-1:0] mask_p0;

  logic              vld_p1;
  logic              wr_p1;
  logic [RESP_W-1:0] resp_push_p1;

  logic [RESP_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign req_fire  = req_valid & ready_r;
  assign resp_fire = resp_valid & resp_ready;
  assign req_ready = ready_r;

  // Credits count requests accepted but not yet consumed as responses.
  always_comb begin
    credits_nxt = credits;
    if (req_fire && !resp_fire)      credits_nxt = credits + 1'b1;
    else if (!req_fire && resp_fire) credits_nxt = credits - 1'b1;
  end

  // Credit state and a registered ready derived from next-cycle credits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credits <= '0;
      ready_r <= 1'b0;
    end else begin
      credits <= credits_nxt;
      ready_r <= (credits_nxt < CNT_W'(DEPTH));
    end
  end

  // ---- stage p0: issue registers drive the SRAM ports for one cycle ----
  // Issue registers are cleared by reset so the macro pins read zero while held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      wr_p0   <= 1'b0;
      addr_p0 <= '0;
      data_p0 <= '0;
      mask_p0 <= '0;
    end else begin
      vld_p0 <= req_fire;
      if (req_fire) begin
        wr_p0   <= req_write;
        addr_p0 <= req_addr;
        data_p0 <= req_data;
        mask_p0 <= req_mask;
      end
    end
  end

  assign W0_clk  = clock;
  assign R0_clk  = clock;
  assign W0_en   = vld_p0 & wr_p0;
  assign R0_en   = vld_p0 & ~wr_p0;
  assign W0_addr = addr_p0;
  assign R0_addr = addr_p0;
  assign W0_data = data_p0;
  assign W0_mask = mask_p0;

  // ---- stage p1: wait for the macro's read data, then queue the response ----
  // Track which issued slot the macro is answering this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      wr_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      wr_p1  <= wr_p0;
    end
  end

  assign resp_push_p1 = {wr_p1, wr_p1 ? {DATA_W{1'b0}} : R0_data};

  sram_resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (resp_push_p1),
    .pop       (resp_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = ~fifo_empty;
  assign {resp_write, resp_data} = fifo_head;

  // Credit construction keeps the queue from overflowing and the ports exclusive.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(vld_p1 && fifo_full && !resp_fire));
      assert (fifo_count <= credits);
      assert (credits <= CNT_W'(DEPTH));
      assert (!(W0_en && R0_en));
    end
  end

endmodule

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master: SRAM macro model, scoreboard monitor and directed/random steps.
module tb_sram_port_master;
  import sram_port_pkg::*;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid, req_write, resp_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [MASK_W-1:0] req_mask;
  logic              req_ready, resp_valid, resp_write;
  logic [DATA_W-1:0] resp_data;
  logic              W0_clk, W0_en, R0_clk, R0_en;
  logic [ADDR_W-1:0] W0_addr, R0_addr;
  logic [DATA_W-1:0] W0_data, R0_data;
  logic [MASK_W-1:0] W0_mask;

  sram_port_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write), .resp_data(resp_data),
    .W0_clk(W0_clk), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_clk(R0_clk), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_d, input logic [63:0] new_d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old_d;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

  // SRAM macro model: masked write, registered read (data valid the cycle after R0_en).
  logic [63:0] sram [logic [ADDR_W-1:0]];
  logic [63:0] rdata = '0;
  always @(posedge W0_clk) begin
    if (W0_en) sram[W0_addr] = merge(sram.exists(W0_addr) ? sram[W0_addr] : 64'h0, W0_data, W0_mask);
  end
  always @(posedge R0_clk) begin
    if (R0_en) rdata <= sram.exists(R0_addr) ? sram[R0_addr] : 64'h0;
  end
  assign R0_data = rdata;

  // Reference model: memory image, expected response queue, outstanding-request count.
  typedef struct {
    sram_resp_t r;
    int         acc;
    int         seen;
  } exp_t;

  logic [63:0] ref_mem [logic [ADDR_W-1:0]];
  exp_t        exp_q [$];
  sram_resp_t  pop_log [$];
  int          lat_log [$];
  int          outst = 0;
  int          cyc = 0;
  bit          armed;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock or posedge reset) armed <= !reset;

  // Monitor: samples on the falling edge, handshakes complete at the following rising edge.
  always @(negedge clock) begin
    exp_t       e;
    sram_resp_t p;
    int         lat;
    if (reset) begin
      exp_q.delete();
      outst = 0;
    end else begin
      chk("ready_vs_credits", 65'(req_ready), armed ? 65'(outst < DEPTH) : 65'(0));
      chk("w0_r0_overlap", 65'(W0_en & R0_en), 65'(0));
      if (exp_q.size() == 0) begin
        chk("spurious_resp", 65'(resp_valid), 65'(0));
      end else if (resp_valid) begin
        e = exp_q[0];
        if (e.seen < 0) begin
          e.seen = cyc;
          exp_q[0] = e;
        end
        chk("resp_head", {resp_write, resp_data}, e.r);
        if (resp_ready) begin
          lat = e.seen - e.acc;
          chk("latency_min", 65'(lat >= 2), 65'(1));
          lat_log.push_back(lat);
          p.write = resp_write;
          p.data  = resp_data;
          pop_log.push_back(p);
          void'(exp_q.pop_front());
          outst--;
        end
      end
      if (req_valid && req_ready) begin
        e.acc  = cyc + 1;
        e.seen = -1;
        if (req_write) begin
          ref_mem[req_addr] = merge(ref_mem.exists(req_addr) ? ref_mem[req_addr] : 64'h0,
                                    req_data, req_mask);
          e.r.write = 1'b1;
          e.r.data  = 64'h0;
        end else begin
          e.r.write = 1'b0;
          e.r.data  = ref_mem.exists(req_addr) ? ref_mem[req_addr] : 64'h0;
        end
        exp_q.push_back(e);
        outst++;
      end
    end
  end

  // Offer one request starting at posedge+1; return at posedge+1 after it is accepted.
  task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [63:0] d,
                      input logic [7:0] m, output int waits);
    waits = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d; req_mask = m;
    forever begin
      @(negedge clock);
      if (req_ready || waits >= 100) break;
      waits++;
      @(posedge clock); #1;
    end
    chk("send_accept", 65'(req_ready), 65'(1));
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_empty", 65'(exp_q.size()), 65'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, maxw, base, lbase, acc;
    req_valid = 0; req_write = 0; req_addr = '0; req_data = '0; req_mask = '0; resp_ready = 0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 65'(req_ready), 65'(0));
    chk("rst_resp_valid", 65'(resp_valid), 65'(0));
    chk("rst_en", 65'({W0_en, R0_en}), 65'(0));
    chk("rst_addr", 65'({W0_addr, R0_addr}), 65'(0));
    chk("rst_data_mask", 65'({W0_data, W0_mask}), 65'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("ready_before_edge", 65'(req_ready), 65'(0));
    @(posedge clock); #1;
    chk("ready_after_edge", 65'(req_ready), 65'(1));

    // Write then read-next-cycle of the same word
    resp_ready = 1'b1;
    base = pop_log.size();
    send(1'b1, 25'h10, 64'h1122334455667788, 8'hFF, w);
    send(1'b0, 25'h10, 64'h0, 8'h00, w);
    drain();
    chk("raw_count", 65'(pop_log.size() - base), 65'(2));
    chk("raw_ack", pop_log[base], {1'b1, 64'h0});
    chk("raw_read", pop_log[base+1], {1'b0, 64'h1122334455667788});

    // Byte-masked write over an existing word
    base = pop_log.size();
    send(1'b1, 25'h3, 64'h0001_0001_0001_0001, 8'hFF, w);
    send(1'b1, 25'h3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, w);
    send(1'b0, 25'h3, 64'h0, 8'h00, w);
    drain();
    chk("mask_read", pop_log[base+2], {1'b0, 64'h0001_0001_FFFF_FFFF});

    // Credit exhaustion with responses stalled
    for (int i = 0; i < 4; i++) send(1'b1, 25'(20 + i), 64'hCAFE_0000_0000_0000 | 64'(i), 8'hFF, w);
    drain();
    resp_ready = 1'b0;
    base = pop_log.size();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 25'(20 + i);
      @(negedge clock);
      if (req_ready) acc++;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    chk("credit_accepts", 65'(acc), 65'(4));
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("credit_ready_low", 65'(req_ready), 65'(0));
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    @(negedge clock);
    chk("credit_ready_back", 65'(req_ready), 65'(1));
    @(posedge clock); #1;
    drain();
    chk("credit_resp_count", 65'(pop_log.size() - base), 65'(4));
    for (int i = 0; i < 4; i++)
      chk("credit_order", pop_log[base+i], {1'b0, 64'hCAFE_0000_0000_0000 | 64'(i)});

    // Full-rate streaming reads
    resp_ready = 1'b1;
    lbase = lat_log.size();
    maxw = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 25'(i), 64'h0, 8'h00, w);
      if (w > maxw) maxw = w;
    end
    drain();
    chk("stream_stall", 65'(maxw), 65'(0));
    chk("stream_count", 65'(lat_log.size() - lbase), 65'(16));
    for (int i = 0; i < 16; i++) chk("stream_latency", 65'(lat_log[lbase+i]), 65'(2));

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = 1'($urandom);
      req_addr   = 25'($urandom_range(0, 15));
      req_data   = {$urandom, $urandom};
      req_mask   = 8'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    drain();

    // Reset with requests in flight
    resp_ready = 1'b0;
    send(1'b0, 25'h5, 64'h0, 8'h00, w);
    send(1'b0, 25'h6, 64'h0, 8'h00, w);
    send(1'b0, 25'h7, 64'h0, 8'h00, w);
    chk("inflight_r0_en", 65'(R0_en), 65'(1));
    chk("inflight_resp_valid", 65'(resp_valid), 65'(1));
    reset = 1'b1;
    #1;
    chk("async_en", 65'({W0_en, R0_en}), 65'(0));
    chk("async_resp_valid", 65'(resp_valid), 65'(0));
    chk("async_req_ready", 65'(req_ready), 65'(0));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    base = pop_log.size();
    resp_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("no_stale_resp", 65'(pop_log.size() - base), 65'(0));
    send(1'b0, 25'h10, 64'h0, 8'h00, w);
    drain();
    chk("post_reset_read", pop_log[pop_log.size()-1], {1'b0, 64'h1122334455667788});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sram_port_master.md
SRAM_PORT_MASTER -- requirements
Module: sram_port_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width.
REQ-003 SHALL have parameter MASK_W, default DATA_W/8, byte-mask width.
REQ-004 SHALL have parameter DEPTH, default 4, maximum outstanding requests (credits).
REQ-005 Port list, in this order:
  clock       in   1       sole clock for all logic
  reset       in   1       asynchronous, active-high reset
  req_valid   in   1       request offered
  req_ready   out  1       request accepted when req_valid & req_ready
  req_write   in   1       1 = write, 0 = read
  req_addr    in   ADDR_W  word address
  req_data    in   DATA_W  write data
  req_mask    in   MASK_W  byte enables, write only
  resp_valid  out  1       response available
  resp_ready  in   1       response consumed when resp_valid & resp_ready
  resp_write  out  1       1 = write ack, 0 = read data
  resp_data   out  DATA_W  read data; 0 for write acks
  W0_clk      out  1       = clock
  W0_addr     out  ADDR_W  SRAM write address
  W0_en       out  1       SRAM write enable
  W0_data     out  DATA_W  SRAM write data
  W0_mask     out  MASK_W  SRAM byte mask
  R0_clk      out  1       = clock
  R0_addr     out  ADDR_W  SRAM read address
  R0_en       out  1       SRAM read enable
  R0_data     in   DATA_W  SRAM read data, valid the cycle after the R0_en edge

Function
REQ-006 Issue stage: SHALL register accepted request (valid, write, addr, data, mask) at accepting edge k.
REQ-007 During cycle k..k+1: W0_en = issue_valid & write; R0_en = issue_valid & ~write; addr/data/mask driven from issue registers.
REQ-008 W0_en and R0_en SHALL never be high in the same cycle.
REQ-009 Capture stage: at edge k+1 SHALL register (valid, write); at edge k+2 SHALL push {write, write ? 0 : R0_data} into response FIFO.
REQ-010 Latency: resp_valid SHALL be high no earlier than the cycle after edge k+2, 2 clocks after acceptance, if the FIFO was empty.
REQ-011 Responses SHALL return in acceptance order; reads SHALL observe every earlier-accepted write, including a write accepted on the immediately preceding cycle.
REQ-012 Credit counter 0..DEPTH: +1 on request handshake, -1 on response handshake, unchanged when both occur in the same cycle.
REQ-013 req_ready SHALL be (credits < DEPTH), registered-only, with no combinational path from resp_ready.
REQ-014 Response FIFO depth DEPTH SHALL never overflow, by credit construction. Overflow is an assertion failure.
REQ-015 resp_valid SHALL equal FIFO non-empty; resp_write/resp_data SHALL show the FIFO head and stay stable while resp_valid & ~resp_ready.
REQ-016 Sustained throughput with resp_ready=1 and DEPTH>=3 SHALL be one request per clock.
REQ-017 FIFO pointers SHALL wrap modulo DEPTH; a simultaneous push and pop on a full or empty FIFO SHALL keep the count correct.

Reset
REQ-018 While reset is high: req_ready=0, resp_valid=0, W0_en=0, R0_en=0, addr/data/mask outputs=0, credits=0, FIFO empty; effect SHALL be immediate (asynchronous).
REQ-019 Reset mid-operation SHALL discard all in-flight and queued responses; no response for pre-reset requests SHALL ever appear.
REQ-020 req_ready SHALL rise on the first clock edge after reset deasserts.

Structure
REQ-021 Package sram_port_pkg SHALL hold default ADDR_W/DATA_W/MASK_W/DEPTH constants and the response struct {write, data}.
REQ-022 Response queue SHALL be sub-module sram_resp_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-023 Write addr 0x10, data 0x1122334455667788, mask 0xFF, then read 0x10 next cycle -> write ack, then read resp_data 0x1122334455667788, in order.
REQ-024 Write addr 0x3, data 0xFFFF_FFFF_FFFF_FFFF, mask 0x0F over initial 0x0001_0001_0001_0001 -> read returns 0x0001_0001_FFFF_FFFF.
REQ-025 resp_ready=0, 6 back-to-back reads -> exactly 4 accepted, req_ready=0 thereafter; one pop -> req_ready=1 the next cycle; all 4 responses in order.
REQ-026 resp_ready=1, 16 back-to-back reads of addr 0..15 -> req_ready never drops, 16 responses on consecutive cycles, first at 2 clocks after acceptance.
REQ-027 Assert reset with 3 requests in flight -> W0_en/R0_en/resp_valid fall immediately; after release, no stale response; a fresh read completes normally.
REQ-028 Random mixed traffic vs. reference memory model -> data match, no W0_en&R0_en overlap, credits always in 0..DEPTH.
